// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared state enum, default program tables and BCD byte type
package wash_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } wash_state_t;

  // Phase durations in minutes, phase 2 (spin) .. phase 0 (wash)
  localparam logic [23:0] PH_DUR_DEF = {8'd6, 8'd15, 8'd12};

  // Phase-enable bits per program, mode 5 .. mode 0
  localparam logic [17:0] MODE_MASK_DEF = {3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b111};

  typedef logic [7:0] bcd_byte_t;

endpackage

// File: rtl/wash_bin2bcd.sv
// rtl/wash_bin2bcd.sv - 8-bit binary to two BCD digits, saturating at 99
module wash_bin2bcd
  import wash_pkg::*;
(
  input  logic [7:0] bin,
  output bcd_byte_t  bcd
);

  logic [3:0] tens;
  logic [3:0] ones;

  // Split into decimal digits; anything above 99 displays as 99
  always_comb begin
    tens = 4'(bin / 8'd10);
    ones = 4'(bin % 8'd10);
    if (bin > 8'd99) begin
      bcd = 8'h99;
    end else begin
      bcd = {tens, ones};
    end
  end

endmodule

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - washing machine program sequencer; WASH_SEQ_AUTO_OFF_EN enables auto power-off
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int                          N_PHASE      = 3,
  parameter int                          N_MODE       = 6,
  parameter int                          SEC_PER_MIN  = 10,
  parameter logic [N_PHASE*8-1:0]        PH_DUR       = PH_DUR_DEF,
  parameter logic [N_MODE*N_PHASE-1:0]   MODE_MASK    = MODE_MASK_DEF,
  parameter int                          ALARM_SEC    = 3,
  parameter int                          AUTO_OFF_SEC = 10
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       TICK,
  input  logic                       KEY_START,
  input  logic                       KEY_MODE,
  output logic [$clog2(N_MODE)-1:0]  MODE,
  output logic [$clog2(N_PHASE)-1:0] PHASE,
  output logic                       RUN,
  output logic [7:0]                 PH_TIME,
  output logic [7:0]                 TOT_TIME,
  output logic                       FINISH,
  output logic                       ALARM,
  output logic                       POWER_OFF
);

  localparam int MW = $clog2(N_MODE);
  localparam int PW = $clog2(N_PHASE);
  localparam logic [7:0]    SEC_LAST   = 8'(SEC_PER_MIN - 1);
  localparam logic [7:0]    ALARM_LAST = 8'(ALARM_SEC - 1);
  localparam logic [MW-1:0] MODE_LAST  = MW'(N_MODE - 1);

  // A phase runs only when enabled for the program and has non-zero duration
  function automatic logic runnable(input int m, input int p);
    logic       en;
    logic [7:0] dur;
    en  = 1'((MODE_MASK >> (m * N_PHASE + p)));
    dur = 8'((PH_DUR >> (p * 8)));
    return en && (dur != 8'd0);
  endfunction

  // Lowest runnable phase at or above 'from', or -1 when none remains
  function automatic int next_run(input int m, input int from);
    int r;
    r = -1;
    for (int p = N_PHASE - 1; p >= 0; p--) begin
      if (p >= from && runnable(m, p)) r = p;
    end
    return r;
  endfunction

  function automatic logic [7:0] dur_of(input int idx);
    if (idx < 0) return 8'd0;
    return 8'((PH_DUR >> (idx * 8)));
  endfunction

  function automatic logic [7:0] mode_total(input int m);
    logic [7:0] s;
    s = 8'd0;
    for (int p = 0; p < N_PHASE; p++) begin
      if (runnable(m, p)) s = s + dur_of(p);
    end
    return s;
  endfunction

  localparam int            RST_IDX   = next_run(0, 0);
  localparam logic [PW-1:0] RST_PHASE = PW'((RST_IDX < 0) ? 0 : RST_IDX);
  localparam logic [7:0]    RST_PH    = dur_of(RST_IDX);
  localparam logic [7:0]    RST_TOT   = mode_total(0);

  wash_state_t   state_q, state_d;
  logic [MW-1:0] mode_q, mode_d, next_mode, rl_mode;
  logic [PW-1:0] phase_q, phase_d, rl_phase;
  logic [7:0]    ph_time_q, ph_time_d, tot_time_q, tot_time_d;
  logic [7:0]    sec_q, sec_d, alarm_cnt_q, alarm_cnt_d;
  logic [7:0]    rl_ph, rl_tot;
  logic          run_q, run_d, finish_q, finish_d, alarm_q, alarm_d;
  int            rl_idx, nx_idx;
`ifdef WASH_SEQ_AUTO_OFF_EN
  localparam logic [7:0] OFF_LAST = 8'(AUTO_OFF_SEC - 1);
  logic [7:0] off_cnt_q, off_cnt_d;
  logic       power_off_q, power_off_d;
`endif

  // Reload values for the program about to be shown, and the phase after the current one
  always_comb begin
    next_mode = (mode_q == MODE_LAST) ? '0 : mode_q + MW'(1);
    rl_mode   = (state_q == S_IDLE && KEY_MODE && !KEY_START) ? next_mode : mode_q;
    rl_idx    = next_run(int'(rl_mode), 0);
    rl_phase  = PW'((rl_idx < 0) ? 0 : rl_idx);
    rl_ph     = dur_of(rl_idx);
    rl_tot    = mode_total(int'(rl_mode));
    nx_idx    = next_run(int'(mode_q), int'(phase_q) + 1);
  end

  // Next-state and countdown logic; a tick is applied before a same-cycle start key toggles
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    phase_d     = phase_q;
    ph_time_d   = ph_time_q;
    tot_time_d  = tot_time_q;
    sec_d       = sec_q;
    finish_d    = 1'b0;
    alarm_d     = alarm_q;
    alarm_cnt_d = alarm_cnt_q;
`ifdef WASH_SEQ_AUTO_OFF_EN
    off_cnt_d   = off_cnt_q;
    power_off_d = power_off_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (KEY_START) begin
          if (ph_time_q != 8'd0) begin
            state_d = S_RUN;
            sec_d   = 8'd0;
          end
        end else if (KEY_MODE) begin
          mode_d     = next_mode;
          phase_d    = rl_phase;
          ph_time_d  = rl_ph;
          tot_time_d = rl_tot;
          sec_d      = 8'd0;
        end
      end
      S_RUN, S_PAUSE: begin
        if (state_q == S_RUN && TICK) begin
          if (sec_q == SEC_LAST) begin
            sec_d      = 8'd0;
            ph_time_d  = ph_time_q - 8'd1;
            tot_time_d = tot_time_q - 8'd1;
            if (ph_time_q == 8'd1) begin
              if (nx_idx >= 0) begin
                phase_d   = PW'(nx_idx);
                ph_time_d = dur_of(nx_idx);
              end else begin
                state_d     = S_DONE;
                ph_time_d   = 8'd0;
                tot_time_d  = 8'd0;
                finish_d    = 1'b1;
                alarm_d     = 1'b1;
                alarm_cnt_d = 8'd0;
`ifdef WASH_SEQ_AUTO_OFF_EN
                off_cnt_d   = 8'd0;
                power_off_d = 1'b0;
`endif
              end
            end
          end else begin
            sec_d = sec_q + 8'd1;
          end
        end
        if (KEY_START && state_d != S_DONE) begin
          state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
        end
      end
      S_DONE: begin
        if (KEY_START || KEY_MODE) begin
          state_d     = S_IDLE;
          phase_d     = rl_phase;
          ph_time_d   = rl_ph;
          tot_time_d  = rl_tot;
          sec_d       = 8'd0;
          alarm_d     = 1'b0;
          alarm_cnt_d = 8'd0;
`ifdef WASH_SEQ_AUTO_OFF_EN
          off_cnt_d   = 8'd0;
          power_off_d = 1'b0;
`endif
        end else if (TICK) begin
          if (alarm_q) begin
            if (alarm_cnt_q == ALARM_LAST) alarm_d = 1'b0;
            else alarm_cnt_d = alarm_cnt_q + 8'd1;
          end
`ifdef WASH_SEQ_AUTO_OFF_EN
          if (!power_off_q) begin
            if (off_cnt_q == OFF_LAST) power_off_d = 1'b1;
            else off_cnt_d = off_cnt_q + 8'd1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    run_d = (state_d == S_RUN);
  end

  // State and registered outputs, reset to the mode-0 program
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      phase_q     <= RST_PHASE;
      ph_time_q   <= RST_PH;
      tot_time_q  <= RST_TOT;
      sec_q       <= 8'd0;
      run_q       <= 1'b0;
      finish_q    <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= 8'd0;
`ifdef WASH_SEQ_AUTO_OFF_EN
      off_cnt_q   <= 8'd0;
      power_off_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      ph_time_q   <= ph_time_d;
      tot_time_q  <= tot_time_d;
      sec_q       <= sec_d;
      run_q       <= run_d;
      finish_q    <= finish_d;
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
`ifdef WASH_SEQ_AUTO_OFF_EN
      off_cnt_q   <= off_cnt_d;
      power_off_q <= power_off_d;
`endif
    end
  end

  wash_bin2bcd u_ph_bcd  (.bin(ph_time_q),  .bcd(PH_TIME));
  wash_bin2bcd u_tot_bcd (.bin(tot_time_q), .bcd(TOT_TIME));

  assign MODE   = mode_q;
  assign PHASE  = phase_q;
  assign RUN    = run_q;
  assign FINISH = finish_q;
  assign ALARM  = alarm_q;
`ifdef WASH_SEQ_AUTO_OFF_EN
  assign POWER_OFF = power_off_q;
`else
  assign POWER_OFF = 1'b0;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - directed self-checking bench for wash_sequencer
module tb_wash_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TICK = 1'b0;
  logic       KEY_START = 1'b0;
  logic       KEY_MODE = 1'b0;
  logic [2:0] MODE;
  logic [1:0] PHASE;
  logic       RUN;
  logic [7:0] PH_TIME;
  logic [7:0] TOT_TIME;
  logic       FINISH;
  logic       ALARM;
  logic       POWER_OFF;

  int errors = 0;
  int checks = 0;
  int fin_cnt = 0;

  logic [7:0] exp_ph    [6] = '{8'h12, 8'h12, 8'h12, 8'h15, 8'h15, 8'h06};
  logic [7:0] exp_tot   [6] = '{8'h33, 8'h12, 8'h27, 8'h15, 8'h21, 8'h06};
  logic [1:0] exp_phase [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
  logic       exp_off;

  wash_sequencer dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .KEY_START(KEY_START), .KEY_MODE(KEY_MODE),
    .MODE(MODE), .PHASE(PHASE), .RUN(RUN), .PH_TIME(PH_TIME), .TOT_TIME(TOT_TIME),
    .FINISH(FINISH), .ALARM(ALARM), .POWER_OFF(POWER_OFF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t, input logic s, input logic m);
    TICK = t; KEY_START = s; KEY_MODE = m;
    @(negedge CLK);
    TICK = 1'b0; KEY_START = 1'b0; KEY_MODE = 1'b0;
    if (FINISH) fin_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("rst_mode", 8'(MODE), 8'd0);
    chk("rst_phase", 8'(PHASE), 8'd0);
    chk("rst_ph", PH_TIME, 8'h12);
    chk("rst_tot", TOT_TIME, 8'h33);
    chk("rst_run", 8'(RUN), 8'd0);
    chk("rst_alarm", 8'(ALARM), 8'd0);
    chk("rst_poff", 8'(POWER_OFF), 8'd0);

    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, 1'b1);
      chk($sformatf("mode%0d_mode", i % 6), 8'(MODE), 8'(i % 6));
      chk($sformatf("mode%0d_phase", i % 6), 8'(PHASE), 8'(exp_phase[i % 6]));
      chk($sformatf("mode%0d_ph", i % 6), PH_TIME, exp_ph[i % 6]);
      chk($sformatf("mode%0d_tot", i % 6), TOT_TIME, exp_tot[i % 6]);
    end

    step(1'b0, 1'b1, 1'b0);
    chk("m0_start_run", 8'(RUN), 8'd1);
    ticks(9);
    chk("m0_t9_ph", PH_TIME, 8'h12);
    ticks(1);
    chk("m0_t10_ph", PH_TIME, 8'h11);
    chk("m0_t10_tot", TOT_TIME, 8'h32);
    step(1'b0, 1'b0, 1'b1);
    chk("m0_keymode_run_ignored", 8'(MODE), 8'd0);
    ticks(115);
    chk("m0_t125_phase", 8'(PHASE), 8'd1);
    chk("m0_t125_ph", PH_TIME, 8'h15);
    chk("m0_t125_tot", TOT_TIME, 8'h21);
    step(1'b0, 1'b1, 1'b0);
    chk("pause_run", 8'(RUN), 8'd0);
    ticks(50);
    step(1'b0, 1'b0, 1'b1);
    chk("pause_mode", 8'(MODE), 8'd0);
    chk("pause_phase", 8'(PHASE), 8'd1);
    chk("pause_ph", PH_TIME, 8'h15);
    chk("pause_tot", TOT_TIME, 8'h21);
    step(1'b0, 1'b1, 1'b0);
    chk("resume_run", 8'(RUN), 8'd1);
    ticks(4);
    chk("resume_t4_ph", PH_TIME, 8'h15);
    step(1'b1, 1'b1, 1'b0);
    chk("coinc_ph", PH_TIME, 8'h14);
    chk("coinc_tot", TOT_TIME, 8'h20);
    chk("coinc_paused", 8'(RUN), 8'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("coinc_resume", 8'(RUN), 8'd1);

    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    chk("midrun_rst_run", 8'(RUN), 8'd0);
    chk("midrun_rst_phase", 8'(PHASE), 8'd0);
    chk("midrun_rst_ph", PH_TIME, 8'h12);
    chk("midrun_rst_tot", TOT_TIME, 8'h33);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    chk("m5_mode", 8'(MODE), 8'd5);
    step(1'b0, 1'b1, 1'b0);
    fin_cnt = 0;
    ticks(59);
    chk("m5_t59_ph", PH_TIME, 8'h01);
    chk("m5_t59_run", 8'(RUN), 8'd1);
    chk("m5_t59_finish", 8'(FINISH), 8'd0);
    ticks(1);
    chk("m5_done_finish", 8'(FINISH), 8'd1);
    chk("m5_done_run", 8'(RUN), 8'd0);
    chk("m5_done_ph", PH_TIME, 8'h00);
    chk("m5_done_tot", TOT_TIME, 8'h00);
    chk("m5_done_alarm", 8'(ALARM), 8'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("m5_finish_drop", 8'(FINISH), 8'd0);
    ticks(1);
    chk("alarm_tick1", 8'(ALARM), 8'd1);
    ticks(1);
    chk("alarm_tick2", 8'(ALARM), 8'd1);
    ticks(1);
    chk("alarm_tick3", 8'(ALARM), 8'd0);
    chk("finish_once", 8'(fin_cnt), 8'd1);

`ifdef WASH_SEQ_AUTO_OFF_EN
    exp_off = 1'b1;
`else
    exp_off = 1'b0;
`endif
    ticks(6);
    chk("poff_tick9", 8'(POWER_OFF), 8'd0);
    ticks(1);
    chk("poff_tick10", 8'(POWER_OFF), 8'(exp_off));
    step(1'b0, 1'b0, 1'b0);
    chk("poff_hold", 8'(POWER_OFF), 8'(exp_off));
    step(1'b0, 1'b0, 1'b1);
    chk("done_key_poff", 8'(POWER_OFF), 8'd0);
    chk("done_key_mode_kept", 8'(MODE), 8'd5);
    chk("done_key_ph", PH_TIME, 8'h06);
    chk("done_key_tot", TOT_TIME, 8'h06);
    chk("done_key_alarm", 8'(ALARM), 8'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("idle_again_mode", 8'(MODE), 8'd0);
    chk("idle_again_ph", PH_TIME, 8'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter N_PHASE, default 3, number of program phases (phase 0 wash, 1 rinse, 2 spin).
REQ-002 Parameter N_MODE, default 6, number of selectable programs.
REQ-003 Parameter SEC_PER_MIN, default 10, TICK strobes per display minute (60 for production).
REQ-004 Parameter PH_DUR, default {6,15,12} (phase 2..0), packed N_PHASE x 8-bit binary minutes per phase.
REQ-005 Parameter MODE_MASK, default {100,110,010,011,001,111} (mode 5..0), packed N_MODE x N_PHASE phase-enable bits.
REQ-006 Parameter ALARM_SEC, default 3, and AUTO_OFF_SEC, default 10, durations in TICKs.
REQ-007 CLK  in  1  system clock; RST  in  1  synchronous, active-high reset.
REQ-008 TICK  in  1  one-cycle 1 Hz enable strobe.
REQ-009 KEY_START  in  1  one-cycle debounced pulse: start/pause/resume.
REQ-010 KEY_MODE  in  1  one-cycle debounced pulse: advance program.
REQ-011 MODE  out  $clog2(N_MODE)  selected program.
REQ-012 PHASE  out  $clog2(N_PHASE)  active phase.
REQ-013 RUN  out  1  high in RUN state only.
REQ-014 PH_TIME  out  8  two BCD digits, minutes left in active phase.
REQ-015 TOT_TIME  out  8  two BCD digits, minutes left in program.
REQ-016 FINISH  out  1  one-cycle pulse on program completion.
REQ-017 ALARM  out  1  completion alarm.
REQ-018 POWER_OFF  out  1  auto power-off request.

Function
REQ-019 States IDLE, RUN, PAUSE, DONE; all outputs registered, updated one cycle after the causing input.
REQ-020 IDLE: KEY_MODE advances MODE, wrapping N_MODE-1 to 0, and reloads PHASE to lowest enabled phase, PH_TIME to its PH_DUR, TOT_TIME to sum of enabled PH_DUR.
REQ-021 Phases with mask bit 0 or PH_DUR 0 are skipped; KEY_START with no runnable phase is ignored.
REQ-022 KEY_START: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; KEY_MODE ignored in RUN and PAUSE.
REQ-023 A TICK counts only if state is RUN in that cycle; seconds counter wraps at SEC_PER_MIN-1 and decrements PH_TIME and TOT_TIME by 1 on wrap.
REQ-024 PAUSE holds seconds counter, PH_TIME, TOT_TIME; resume continues without loss.
REQ-025 When PH_TIME decrements to 0, the same cycle loads the next enabled phase and its PH_DUR; if none remains, enter DONE, PH_TIME=TOT_TIME=0, FINISH pulses once.
REQ-026 KEY_START and TICK in the same cycle: tick is applied per REQ-023, then state toggles.
REQ-027 DONE: ALARM high for ALARM_SEC TICKs after entry; KEY_START or KEY_MODE returns to IDLE with MODE kept and times reloaded.
REQ-028 Arithmetic binary internally, 8-bit; BCD conversion saturates at 99.

Reset
REQ-029 RST, at any state: IDLE, MODE 0, PHASE/PH_TIME/TOT_TIME reloaded for mode 0, seconds counter 0, RUN/FINISH/ALARM/POWER_OFF 0.

Configuration
REQ-030 WASH_SEQ_AUTO_OFF_EN defined: in DONE, after AUTO_OFF_SEC TICKs with no key, POWER_OFF goes high and holds until a key or RST, either clearing it and returning to IDLE.
REQ-031 WASH_SEQ_AUTO_OFF_EN undefined: POWER_OFF tied 0, no auto-off counter instantiated, port retained.

Structure
REQ-032 Package wash_pkg holds state enum, default PH_DUR/MODE_MASK constants, BCD byte typedef.
REQ-033 One sub-module wash_bin2bcd: 8-bit binary to two BCD digits, saturating, combinational, instantiated twice.

Verification
REQ-034 RST, defaults -> MODE 0, PH_TIME 0x12, TOT_TIME 0x33, RUN 0.
REQ-035 KEY_MODE x6 from reset -> MODE 1,2,3,4,5,0; mode 3 shows PHASE 1, PH_TIME 0x15, TOT_TIME 0x15.
REQ-036 Mode 5, KEY_START, 60 TICKs -> FINISH pulse once, DONE, ALARM high exactly 3 TICKs.
REQ-037 Mode 0 run 125 TICKs -> PHASE 1, PH_TIME 0x15, TOT_TIME 0x21; PAUSE 50 TICKs -> values unchanged.
REQ-038 KEY_START coincident with 10th TICK -> PH_TIME decrements and state PAUSE next cycle.
REQ-039 With WASH_SEQ_AUTO_OFF_EN, DONE + 10 TICKs -> POWER_OFF 1; KEY_MODE -> POWER_OFF 0, IDLE; RST mid-RUN -> reset values next cycle.
